// File: rtl/uart_host_master.sv
// Host-side initiator for the UART register-access link: sends one 8-byte request frame,
// then hunts for and checks the 7-byte response, reporting OK, FAIL or TIMEOUT.
module uart_host_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned TO_W           = 24
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic        CMD_WR,
  input  logic [7:0]  CMD_ADDR,
  input  logic [31:0] CMD_WDATA,
  output logic [7:0]  TX_DATA,
  output logic        TX_START,
  input  logic        TX_BUSY,
  input  logic [7:0]  RX_DATA,
  input  logic        RX_DONE,
  output logic        RSP_VALID,
  output logic [31:0] RSP_RDATA,
  output logic        RSP_OK,
  output logic        RSP_FAIL,
  output logic        RSP_TIMEOUT
);

  typedef enum logic [2:0] {
    StIdle,
    StTxLoad,
    StTxWait,
    StRxHunt,
    StRxBody,
    StReport
  } state_e;

  localparam logic [TO_W-1:0] ToReload = TO_W'(TIMEOUT_CYCLES);

  state_e          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic            guard_q, guard_d;
  logic            wr_q, wr_d;
  logic [7:0]      addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            tx_start_q, tx_start_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]      xor_q, xor_d;
  logic [7:0]      status_q, status_d;
  logic [31:0]     shadow_q, shadow_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            ok_q, ok_d;
  logic            fail_q, fail_d;
  logic            tmo_q, tmo_d;

  logic [7:0] cmd_byte;
  logic [7:0] chk_byte;
  logic [7:0] req_byte;

  // wdata_q is already zeroed for reads, so the checksum needs no read/write split
  assign cmd_byte = wr_q ? 8'h57 : 8'h52;
  assign chk_byte = 8'hAA ^ cmd_byte ^ addr_q ^ wdata_q[31:24] ^ wdata_q[23:16]
                  ^ wdata_q[15:8] ^ wdata_q[7:0];

  always_comb begin
    req_byte = 8'h00;
    unique case (idx_q)
      3'd0: req_byte = 8'hAA;
      3'd1: req_byte = cmd_byte;
      3'd2: req_byte = addr_q;
      3'd3: req_byte = wdata_q[31:24];
      3'd4: req_byte = wdata_q[23:16];
      3'd5: req_byte = wdata_q[15:8];
      3'd6: req_byte = wdata_q[7:0];
      3'd7: req_byte = chk_byte;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    guard_d    = guard_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    to_cnt_d   = to_cnt_q;
    xor_d      = xor_q;
    status_d   = status_q;
    shadow_d   = shadow_q;
    rdata_d    = rdata_q;
    ok_d       = 1'b0;
    fail_d     = 1'b0;
    tmo_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (CMD_VALID) begin
          wr_d    = CMD_WR;
          addr_d  = CMD_ADDR;
          wdata_d = CMD_WR ? CMD_WDATA : 32'h0;
          idx_d   = 3'd0;
          state_d = StTxLoad;
        end
      end
      StTxLoad: begin
        if (!TX_BUSY) begin
          tx_start_d = 1'b1;
          tx_data_d  = req_byte;
          guard_d    = 1'b1;
          state_d    = StTxWait;
        end
      end
      StTxWait: begin
        // Guard cycle gives the transmitter time to raise TX_BUSY after the start pulse
        if (guard_q) begin
          guard_d = 1'b0;
        end else if (!TX_BUSY) begin
          if (idx_q == 3'd7) begin
            to_cnt_d = ToReload;
            state_d  = StRxHunt;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = StTxLoad;
          end
        end
      end
      StRxHunt, StRxBody: begin
        if (RX_DONE) begin
          to_cnt_d = ToReload;
          if (state_q == StRxHunt) begin
            if (RX_DATA == 8'h55) begin
              xor_d   = RX_DATA;
              idx_d   = 3'd1;
              state_d = StRxBody;
            end
          end else begin
            xor_d = xor_q ^ RX_DATA;
            if (idx_q == 3'd1) begin
              status_d = RX_DATA;
            end else if (idx_q <= 3'd5) begin
              shadow_d = {shadow_q[23:0], RX_DATA};
            end
            if (idx_q == 3'd6) begin
              state_d = StReport;
              if ((xor_q != RX_DATA) || (status_q != 8'h00)) begin
                fail_d = 1'b1;
              end else begin
                ok_d = 1'b1;
                if (!wr_q) begin
                  rdata_d = shadow_q;
                end
              end
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end
        end else if (to_cnt_q <= TO_W'(1)) begin
          to_cnt_d = '0;
          tmo_d    = 1'b1;
          state_d  = StReport;
        end else begin
          to_cnt_d = to_cnt_q - TO_W'(1);
        end
      end
      StReport: begin
        idx_d   = 3'd0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= StIdle;
      idx_q      <= 3'd0;
      guard_q    <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= 8'h00;
      wdata_q    <= 32'h0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      to_cnt_q   <= '0;
      xor_q      <= 8'h00;
      status_q   <= 8'h00;
      shadow_q   <= 32'h0;
      rdata_q    <= 32'h0;
      ok_q       <= 1'b0;
      fail_q     <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      guard_q    <= guard_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      to_cnt_q   <= to_cnt_d;
      xor_q      <= xor_d;
      status_q   <= status_d;
      shadow_q   <= shadow_d;
      rdata_q    <= rdata_d;
      ok_q       <= ok_d;
      fail_q     <= fail_d;
      tmo_q      <= tmo_d;
    end
  end

  assign CMD_READY   = (state_q == StIdle);
  assign TX_START    = tx_start_q;
  assign TX_DATA     = tx_data_q;
  assign RSP_VALID   = (state_q == StReport);
  assign RSP_RDATA   = rdata_q;
  assign RSP_OK      = ok_q;
  assign RSP_FAIL    = fail_q;
  assign RSP_TIMEOUT = tmo_q;

endmodule

// File: tb/tb_uart_host_master.sv
// Directed scoreboard bench for uart_host_master: request bytes and responses are predicted
// by a small frame model and compared as the DUT emits them.
module tb_uart_host_master;

  localparam int unsigned TIMEOUT = 100;
  localparam int          BUSY    = 10;

  typedef struct {
    logic        ok;
    logic        fail;
    logic        tmo;
    logic [31:0] rdata;
    int          due;
  } rsp_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        CMD_VALID = 1'b0;
  logic        CMD_READY;
  logic        CMD_WR = 1'b0;
  logic [7:0]  CMD_ADDR = 8'h00;
  logic [31:0] CMD_WDATA = 32'h0;
  logic [7:0]  TX_DATA;
  logic        TX_START;
  logic        TX_BUSY;
  logic [7:0]  RX_DATA = 8'h00;
  logic        RX_DONE = 1'b0;
  logic        RSP_VALID;
  logic [31:0] RSP_RDATA;
  logic        RSP_OK;
  logic        RSP_FAIL;
  logic        RSP_TIMEOUT;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int busy_cnt = 0;
  int tx_seen = 0;
  int rsp_seen = 0;
  int last_tx_cyc = 0;
  int last_rx_cyc = 0;
  logic [7:0] exp_tx[$];
  rsp_t       exp_rsp[$];

  uart_host_master #(
    .TIMEOUT_CYCLES(TIMEOUT),
    .TO_W          (8)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .CMD_VALID  (CMD_VALID),
    .CMD_READY  (CMD_READY),
    .CMD_WR     (CMD_WR),
    .CMD_ADDR   (CMD_ADDR),
    .CMD_WDATA  (CMD_WDATA),
    .TX_DATA    (TX_DATA),
    .TX_START   (TX_START),
    .TX_BUSY    (TX_BUSY),
    .RX_DATA    (RX_DATA),
    .RX_DONE    (RX_DONE),
    .RSP_VALID  (RSP_VALID),
    .RSP_RDATA  (RSP_RDATA),
    .RSP_OK     (RSP_OK),
    .RSP_FAIL   (RSP_FAIL),
    .RSP_TIMEOUT(RSP_TIMEOUT)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Transmitter model: busy for BUSY cycles after each start pulse
  always @(posedge CLK) begin
    if (TX_START) busy_cnt <= BUSY;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign TX_BUSY = (busy_cnt != 0);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin : tx_monitor
    logic [7:0] e;
    forever begin
      @(negedge CLK);
      if (TX_START) begin
        tx_seen++;
        last_tx_cyc = cyc;
        if (exp_tx.size() == 0) begin
          tests++;
          fails++;
          $error("FAIL tx_extra: observed byte %0h expected none", TX_DATA);
        end else begin
          e = exp_tx.pop_front();
          check("tx_byte", 64'(TX_DATA), 64'(e));
        end
      end
    end
  end

  initial begin : rsp_monitor
    rsp_t e;
    forever begin
      @(negedge CLK);
      if (RSP_VALID) begin
        rsp_seen++;
        if (exp_rsp.size() == 0) begin
          tests++;
          fails++;
          $error("FAIL rsp_extra: observed response expected none");
        end else begin
          e = exp_rsp.pop_front();
          check("rsp_flags", 64'({RSP_OK, RSP_FAIL, RSP_TIMEOUT}), 64'({e.ok, e.fail, e.tmo}));
          check("rsp_rdata", 64'(RSP_RDATA), 64'(e.rdata));
          if (e.due >= 0) check("rsp_cycle", 64'(cyc), 64'(e.due));
        end
      end
    end
  end

  task automatic push_req(input logic wr, input logic [7:0] addr, input logic [31:0] wd);
    logic [7:0]  b[8];
    logic [31:0] d;
    d = wr ? wd : 32'h0;
    b[0] = 8'hAA;
    b[1] = wr ? 8'h57 : 8'h52;
    b[2] = addr;
    b[3] = d[31:24];
    b[4] = d[23:16];
    b[5] = d[15:8];
    b[6] = d[7:0];
    b[7] = 8'h00;
    for (int i = 0; i < 7; i++) b[7] = b[7] ^ b[i];
    for (int i = 0; i < 8; i++) exp_tx.push_back(b[i]);
  endtask

  task automatic push_rsp(input logic ok, input logic fail, input logic tmo,
                          input logic [31:0] rdata, input int due);
    rsp_t r;
    r.ok = ok; r.fail = fail; r.tmo = tmo; r.rdata = rdata; r.due = due;
    exp_rsp.push_back(r);
  endtask

  task automatic send_cmd(input logic wr, input logic [7:0] addr, input logic [31:0] wd);
    int n = 0;
    while (!CMD_READY && n < 500) begin
      @(negedge CLK);
      n++;
    end
    check("cmd_ready_wait", 64'(CMD_READY), 64'd1);
    push_req(wr, addr, wd);
    @(posedge CLK);
    #1;
    CMD_VALID = 1'b1;
    CMD_WR    = wr;
    CMD_ADDR  = addr;
    CMD_WDATA = wd;
    @(posedge CLK);
    #1;
    CMD_VALID = 1'b0;
    check("cmd_ready_drop", 64'(CMD_READY), 64'd0);
  endtask

  task automatic wait_tx(input int target);
    int n = 0;
    while (tx_seen < target && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    check("tx_count", 64'(tx_seen >= target), 64'd1);
  endtask

  task automatic wait_rsp(input int target);
    int n = 0;
    while (rsp_seen < target && n < 500) begin
      @(negedge CLK);
      n++;
    end
    check("rsp_count", 64'(rsp_seen >= target), 64'd1);
    @(negedge CLK);
    check("rsp_clear", 64'({RSP_VALID, RSP_OK, RSP_FAIL, RSP_TIMEOUT, CMD_READY}), 64'h1);
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(posedge CLK);
    #1;
    RX_DATA = b;
    RX_DONE = 1'b1;
    last_rx_cyc = cyc;
    @(posedge CLK);
    #1;
    RX_DONE = 1'b0;
  endtask

  task automatic send_rsp(input logic [7:0] st, input logic [31:0] d, input logic [7:0] chk_flip);
    logic [7:0] chk;
    chk = 8'h55 ^ st ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
    send_rx(8'h55);
    send_rx(st);
    send_rx(d[31:24]);
    send_rx(d[23:16]);
    send_rx(d[15:8]);
    send_rx(d[7:0]);
    send_rx(chk ^ chk_flip);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin : stimulus
    int base;
    // Reset state
    idle(3);
    check("rst_ready", 64'(CMD_READY), 64'd1);
    check("rst_tx", 64'({TX_START, TX_DATA}), 64'd0);
    check("rst_rsp", 64'({RSP_VALID, RSP_OK, RSP_FAIL, RSP_TIMEOUT}), 64'd0);
    check("rst_rdata", 64'(RSP_RDATA), 64'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;

    // Write, OK response; RSP_RDATA untouched by a write
    base = tx_seen;
    send_cmd(1'b1, 8'h10, 32'h12345678);
    wait_tx(base + 8);
    idle(15);
    push_rsp(1'b1, 1'b0, 1'b0, 32'h0, -1);
    send_rsp(8'h00, 32'h0, 8'h00);
    wait_rsp(1);

    // Read with data
    base = tx_seen;
    send_cmd(1'b0, 8'h20, 32'hFFFF_FFFF);
    wait_tx(base + 8);
    idle(15);
    push_rsp(1'b1, 1'b0, 1'b0, 32'hDEADBEEF, -1);
    send_rsp(8'h00, 32'hDEADBEEF, 8'h00);
    wait_rsp(2);

    // Non-zero status
    base = tx_seen;
    send_cmd(1'b0, 8'h20, 32'h0);
    wait_tx(base + 8);
    idle(15);
    push_rsp(1'b0, 1'b1, 1'b0, 32'hDEADBEEF, -1);
    send_rsp(8'h01, 32'h0, 8'h00);
    wait_rsp(3);

    // Bad checksum: data must not reach RSP_RDATA
    base = tx_seen;
    send_cmd(1'b0, 8'h21, 32'h0);
    wait_tx(base + 8);
    idle(15);
    push_rsp(1'b0, 1'b1, 1'b0, 32'hDEADBEEF, -1);
    send_rsp(8'h00, 32'h11223344, 8'h69);
    wait_rsp(4);

    // Stray 0x55 during TX, junk before header
    base = tx_seen;
    send_cmd(1'b0, 8'h30, 32'h0);
    wait_tx(base + 2);
    send_rx(8'h55);
    wait_tx(base + 8);
    idle(15);
    send_rx(8'h00);
    send_rx(8'hFF);
    push_rsp(1'b1, 1'b0, 1'b0, 32'hCAFEBABE, -1);
    send_rsp(8'h00, 32'hCAFEBABE, 8'h00);
    wait_rsp(5);

    // No response: timeout 100 cycles after leaving TX_WAIT
    base = tx_seen;
    send_cmd(1'b0, 8'h40, 32'h0);
    wait_tx(base + 8);
    push_rsp(1'b0, 1'b0, 1'b1, 32'hCAFEBABE, last_tx_cyc + BUSY + 2 + TIMEOUT);
    wait_rsp(6);

    // Bytes 90 cycles apart keep reloading; timeout follows the last one
    base = tx_seen;
    send_cmd(1'b0, 8'h44, 32'h0);
    wait_tx(base + 8);
    idle(20);
    send_rx(8'h55);
    idle(88);
    send_rx(8'h00);
    idle(88);
    send_rx(8'hDE);
    push_rsp(1'b0, 1'b0, 1'b1, 32'hCAFEBABE, last_rx_cyc + 1 + TIMEOUT);
    wait_rsp(7);

    // Reset after the 4th request byte, then a clean frame
    base = tx_seen;
    send_cmd(1'b1, 8'h50, 32'hA5A5A5A5);
    wait_tx(base + 4);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    #1;
    exp_tx.delete();
    check("midrst_tx_start", 64'(TX_START), 64'd0);
    check("midrst_ready", 64'(CMD_READY), 64'd1);
    check("midrst_rdata", 64'(RSP_RDATA), 64'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    base = tx_seen;
    send_cmd(1'b1, 8'h50, 32'hA5A5A5A5);
    wait_tx(base + 8);
    idle(15);
    push_rsp(1'b1, 1'b0, 1'b0, 32'h0, -1);
    send_rsp(8'h00, 32'h0, 8'h00);
    wait_rsp(8);

    idle(5);
    check("tx_queue_empty", 64'(exp_tx.size()), 64'd0);
    check("rsp_queue_empty", 64'(exp_rsp.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_host_master.md
Name: uart_host_master

Overview:
Initiator end of the UART register-access link. It accepts one read or write command, serializes it into an 8-byte request frame for a byte-level UART transmitter, then collects and checks the 7-byte response frame from a byte-level UART receiver. It reports the read data and an OK, FAIL or TIMEOUT status. It sits on the host/test side, opposite the FPGA receive/decode/register/encode chain.

Parameters:
TIMEOUT_CYCLES, 1000000, maximum CLK cycles allowed between the last request byte and each response byte.
TO_W, 24, timeout counter width; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
CLK  in  1  system clock
RST  in  1  reset, asynchronous, active-high
CMD_VALID  in  1  command request
CMD_READY  out  1  high only in IDLE
CMD_WR  in  1  1 = write, 0 = read
CMD_ADDR  in  8  register address
CMD_WDATA  in  32  write data; ignored for reads
TX_DATA  out  8  byte to the UART transmitter
TX_START  out  1  one-cycle pulse that launches TX_DATA
TX_BUSY  in  1  transmitter busy
RX_DATA  in  8  received byte
RX_DONE  in  1  one-cycle pulse; RX_DATA is valid on this cycle
RSP_VALID  out  1  one-cycle completion pulse
RSP_RDATA  out  32  response data; held until the next RSP_VALID
RSP_OK  out  1  status qualifier, valid with RSP_VALID
RSP_FAIL  out  1  status qualifier, valid with RSP_VALID
RSP_TIMEOUT  out  1  status qualifier, valid with RSP_VALID

Behaviour:
- Reset (asynchronous, any state): FSM goes to IDLE. CMD_READY=1. TX_START=0, TX_DATA=0. RSP_VALID/OK/FAIL/TIMEOUT=0. RSP_RDATA=0. Byte counters and timeout counter = 0.
- Request frame, sent in this order: 0xAA, CMD (0x57 write / 0x52 read), ADDR, WDATA[31:24], [23:16], [15:8], [7:0], CHK.
  - Reads send data bytes 0x00.
  - CHK = XOR of the 7 preceding bytes.
- Response frame: 0x55, STATUS, D[31:24], D[23:16], D[15:8], D[7:0], CHK.
  - CHK = XOR of the 6 preceding bytes.
- States: IDLE -> TX_LOAD -> TX_WAIT -> (TX_LOAD | RX_HUNT) ; RX_HUNT -> RX_BODY -> REPORT -> IDLE.
- IDLE:
  - A cycle with CMD_VALID & CMD_READY captures CMD_WR, CMD_ADDR and CMD_WDATA into the frame.
  - CMD_READY drops the next cycle. Byte index = 0.
- TX_LOAD:
  - If TX_BUSY=0: drive TX_DATA and pulse TX_START for exactly one cycle, then go to TX_WAIT.
  - If TX_BUSY=1: hold without pulsing.
- TX_WAIT:
  - One mandatory guard cycle, then wait for TX_BUSY=0.
  - Index < 7: increment and return to TX_LOAD.
  - Index = 7: load the timeout counter with TIMEOUT_CYCLES and go to RX_HUNT.
  - Result: no back-to-back TX_START pulses; minimum spacing is 3 cycles.
- RX_DONE is ignored in IDLE, TX_LOAD and TX_WAIT; stray bytes are dropped.
- RX_HUNT:
  - RX_DONE with 0x55: start the running XOR, go to RX_BODY, index = 1.
  - Any other byte: discard and keep hunting.
- RX_BODY:
  - Each RX_DONE shifts data bytes into the RSP_RDATA shadow register, MSB first, and updates the XOR.
  - After byte 6 (CHK), go to REPORT.
- Timeout:
  - In RX_HUNT and RX_BODY the counter decrements every cycle.
  - Every RX_DONE reloads it to TIMEOUT_CYCLES.
  - Reaching 0 goes to REPORT with the timeout flag set.
  - If RX_DONE and expiry occur in the same cycle, RX_DONE wins (reload, no timeout).
- REPORT (1 cycle): RSP_VALID=1 and exactly one status flag is set:
  - RSP_TIMEOUT on expiry.
  - Else RSP_FAIL if the checksum mismatches or STATUS != 0x00.
  - Else RSP_OK.
  - RSP_RDATA updates only for RSP_OK on a read; otherwise the previous value is held.
  - Then return to IDLE, CMD_READY=1.
- Status flags are cleared on the cycle after REPORT.
- Latency: a new command is accepted at the earliest on the cycle after RSP_VALID.

Test Plan:
- Write: CMD_WR=1, ADDR=0x10, WDATA=0x12345678, TX_BUSY modeled 10 cycles per byte -> TX bytes AA 57 10 12 34 56 78 E5. Then feed 55 00 00 00 00 00 55 -> RSP_VALID with RSP_OK=1 and RSP_RDATA unchanged.
- Read: ADDR=0x20 -> TX bytes AA 52 20 00 00 00 00 D8. Feed 55 00 DE AD BE EF 77 -> RSP_OK=1, RSP_RDATA=0xDEADBEEF.
- Error response: read, then feed 55 01 00 00 00 00 54 -> RSP_FAIL=1. Separately feed a bad CHK (0x78 instead of 0x77) -> RSP_FAIL=1 and RSP_RDATA unchanged.
- Hunt: feed 00 FF before a valid response, and an RX_DONE during the TX phase -> stray bytes ignored, RSP_OK=1.
- Timeout: TIMEOUT_CYCLES=100, no response -> RSP_TIMEOUT=1 exactly 100 cycles after the TX_WAIT exit. Also feed 3 bytes spaced 90 cycles apart then stop -> timeout 100 cycles after the 3rd byte.
- Reset mid-frame: assert RST after the 4th TX byte -> TX_START=0 and CMD_READY=1 immediately. The next command sends a complete, correct frame starting with 0xAA.
